// File: rtl/gerenciador_vidas_if.sv
// ----------------------------------------------------------------------------
// gerenciador_vidas_if
//
// Signal bundle between the game control/datapath and the lives manager.
// Clock and reset are not part of the bundle; they stay plain module ports.
//
//   carrega        : load strobe, loads the life count from vidas_iniciais
//   vidas_iniciais : requested starting lives (3 bits)
//   colisao        : collision level from the datapath
//   ganha_vida     : extra-life pulse (used only with VIDA_EXTRA_EN)
//   vidas          : current life count (3 bits)
//   invulneravel   : invulnerability window open
//   acerto         : one-cycle pulse per life lost
//   sem_vidas      : no lives remain
//   db_estado      : debug state code (3 bits)
//
// Modports:
//   master : the side driving the requests (control unit / testbench)
//   slave  : the lives manager itself
// ----------------------------------------------------------------------------
interface gerenciador_vidas_if;
    logic       carrega;
    logic [2:0] vidas_iniciais;
    logic       colisao;
    logic       ganha_vida;
    logic [2:0] vidas;
    logic       invulneravel;
    logic       acerto;
    logic       sem_vidas;
    logic [2:0] db_estado;

    modport master (
        output carrega,
        output vidas_iniciais,
        output colisao,
        output ganha_vida,
        input  vidas,
        input  invulneravel,
        input  acerto,
        input  sem_vidas,
        input  db_estado
    );

    modport slave (
        input  carrega,
        input  vidas_iniciais,
        input  colisao,
        input  ganha_vida,
        output vidas,
        output invulneravel,
        output acerto,
        output sem_vidas,
        output db_estado
    );
endinterface

// File: rtl/gerenciador_vidas.sv
// ----------------------------------------------------------------------------
// gerenciador_vidas
//
// Lives manager and collision scheduler. Owns the player's life counter,
// turns datapath collisions into life losses, opens a fixed invulnerability
// window after each hit and flags when the last life is gone.
//
// Parameters:
//   MAX_VIDAS     : maximum / saturation life count (1..7)
//   INVULN_CICLOS : invulnerability window length in cycles (>= 2)
//   CW            : window counter width, 2**CW >= INVULN_CICLOS
//
// Ports:
//   clock   : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : gerenciador_vidas_if.slave (load/collision inputs,
//             lives/status outputs)
//
// Optional feature macro: VIDA_EXTRA_EN
//   defined   -> ganha_vida adds a life (saturating) in ATIVO and INVULN
//   undefined -> ganha_vida is ignored
// ----------------------------------------------------------------------------
module gerenciador_vidas #(
    parameter int MAX_VIDAS     = 7,
    parameter int INVULN_CICLOS = 50_000_000,
    parameter int CW            = 26
) (
    input  logic                  clock,
    input  logic                  reset_n,
    gerenciador_vidas_if.slave    bus
);

    typedef enum logic [2:0] {
        OCIOSO = 3'd0,
        ATIVO  = 3'd1,
        ACERTO = 3'd2,
        INVULN = 3'd3,
        MORTO  = 3'd4
    } estado_t;

    localparam logic [2:0]    MAX_V  = 3'(MAX_VIDAS);
    localparam logic [CW-1:0] ULTIMO = CW'(INVULN_CICLOS - 1);

    estado_t       estado_q, estado_d;
    logic [2:0]    vidas_q,  vidas_d;
    logic [CW-1:0] cont_q,   cont_d;

    logic [2:0]    vidas_carga;
    logic [2:0]    vidas_mais_um;

    // Requested lives clamped into 1..MAX_VIDAS.
    always_comb begin
        vidas_carga = bus.vidas_iniciais;
        if (bus.vidas_iniciais == 3'd0) begin
            vidas_carga = 3'd1;
        end else if (bus.vidas_iniciais > MAX_V) begin
            vidas_carga = MAX_V;
        end
    end

    // Saturating increment, only used by the extra-life feature.
    always_comb begin
        vidas_mais_um = vidas_q;
        if (vidas_q < MAX_V) begin
            vidas_mais_um = vidas_q + 3'd1;
        end
    end

`ifndef VIDA_EXTRA_EN
    logic unused_ganha_vida;
    assign unused_ganha_vida = bus.ganha_vida;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q <= OCIOSO;
            vidas_q  <= '0;
            cont_q   <= '0;
        end else begin
            estado_q <= estado_d;
            vidas_q  <= vidas_d;
            cont_q   <= cont_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        vidas_d  = vidas_q;
        cont_d   = cont_q;

        if (bus.carrega) begin
            // Load wins over everything, including a hit already being
            // processed: the decrement is overwritten and no pulse follows.
            estado_d = ATIVO;
            vidas_d  = vidas_carga;
            cont_d   = '0;
        end else begin
            case (estado_q)
                OCIOSO: begin
                end

                ATIVO: begin
                    // vidas >= 1 here, so the decrement cannot underflow.
                    if (bus.colisao) begin
                        estado_d = ACERTO;
                        vidas_d  = vidas_q - 3'd1;
                    end
`ifdef VIDA_EXTRA_EN
                    else if (bus.ganha_vida) begin
                        vidas_d = vidas_mais_um;
                    end
`endif
                end

                ACERTO: begin
                    cont_d = '0;
                    if (vidas_q == 3'd0) begin
                        estado_d = MORTO;
                    end else begin
                        estado_d = INVULN;
                    end
                end

                INVULN: begin
                    if (cont_q == ULTIMO) begin
                        estado_d = ATIVO;
                        cont_d   = '0;
                    end else begin
                        cont_d = cont_q + CW'(1);
                    end
`ifdef VIDA_EXTRA_EN
                    if (bus.ganha_vida) begin
                        vidas_d = vidas_mais_um;
                    end
`endif
                end

                MORTO: begin
                end

                default: begin
                    estado_d = OCIOSO;
                end
            endcase
        end
    end

    assign bus.vidas        = vidas_q;
    assign bus.acerto       = (estado_q == ACERTO);
    assign bus.invulneravel = (estado_q == ACERTO) || (estado_q == INVULN);
    assign bus.sem_vidas    = (estado_q == MORTO);
    assign bus.db_estado    = estado_q;

endmodule

// File: tb/tb_gerenciador_vidas.sv
module tb_gerenciador_vidas;

    localparam int N    = 4;
    localparam int MAXV = 7;

`ifdef VIDA_EXTRA_EN
    localparam bit EXTRA = 1'b1;
`else
    localparam bit EXTRA = 1'b0;
`endif

    logic clock;
    logic reset_n;

    gerenciador_vidas_if bus_if ();

    gerenciador_vidas #(
        .MAX_VIDAS    (MAXV),
        .INVULN_CICLOS(N),
        .CW           (3)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: life count, whether a game has been loaded, and the
    // number of invulnerable cycles still to go (N+1 means "the hit cycle").
    int m_lives  = 0;
    bit m_loaded = 1'b0;
    int m_inv    = 0;

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_cmp++;
        assert (obs === exp_v)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic void model_reset();
        m_lives  = 0;
        m_loaded = 1'b0;
        m_inv    = 0;
    endfunction

    function automatic void model_edge(input bit c, input int vi, input bit col, input bit gv);
        if (c) begin
            m_loaded = 1'b1;
            m_lives  = (vi == 0) ? 1 : ((vi > MAXV) ? MAXV : vi);
            m_inv    = 0;
        end else if (!m_loaded) begin
            // idle until first load
        end else if (m_inv == N + 1) begin
            m_inv = (m_lives == 0) ? 0 : N;
        end else if (m_inv > 0) begin
            m_inv = m_inv - 1;
            if (EXTRA && gv && m_lives < MAXV) m_lives = m_lives + 1;
        end else if (m_lives == 0) begin
            // game over: frozen
        end else if (col) begin
            m_lives = m_lives - 1;
            m_inv   = N + 1;
        end else if (EXTRA && gv && m_lives < MAXV) begin
            m_lives = m_lives + 1;
        end
    endfunction

    task automatic check_all();
        int e_db;
        bit dead;
        dead = m_loaded && (m_inv == 0) && (m_lives == 0);
        if (!m_loaded)          e_db = 0;
        else if (m_inv == N + 1) e_db = 2;
        else if (m_inv > 0)     e_db = 3;
        else if (m_lives == 0)  e_db = 4;
        else                    e_db = 1;
        chk("vidas",        int'(bus_if.vidas),        m_lives);
        chk("acerto",       int'(bus_if.acerto),       int'(m_inv == N + 1));
        chk("invulneravel", int'(bus_if.invulneravel), int'(m_inv > 0));
        chk("sem_vidas",    int'(bus_if.sem_vidas),    int'(dead));
        chk("db_estado",    int'(bus_if.db_estado),    e_db);
    endtask

    task automatic step(input bit c, input int vi, input bit col, input bit gv);
        bus_if.carrega        = c;
        bus_if.vidas_iniciais = 3'(vi);
        bus_if.colisao        = col;
        bus_if.ganha_vida     = gv;
        @(posedge clock);
        model_edge(c, vi, col, gv);
        #1;
        check_all();
    endtask

    task automatic async_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        int pulses;
        int win;
        int hits[$];

        reset_n               = 1'b0;
        bus_if.carrega        = 1'b0;
        bus_if.vidas_iniciais = 3'd0;
        bus_if.colisao        = 1'b0;
        bus_if.ganha_vida     = 1'b0;
        #2;
        model_reset();
        check_all();
        @(posedge clock);
        #1;
        check_all();
        @(negedge clock);
        reset_n = 1'b1;

        // Inputs ignored before the first load.
        step(0, 0, 1, 1);
        step(0, 0, 1, 0);

        // Reset and load.
        step(1, 3, 0, 0);
        chk("load3_vidas", int'(bus_if.vidas), 3);
        chk("load3_db", int'(bus_if.db_estado), 1);

        // Single hit: one pulse, window of N+1 cycles.
        pulses = 0;
        win    = 0;
        step(0, 0, 1, 0);
        pulses += int'(bus_if.acerto);
        win    += int'(bus_if.invulneravel);
        chk("hit_vidas", int'(bus_if.vidas), 2);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 0);
            pulses += int'(bus_if.acerto);
            win    += int'(bus_if.invulneravel);
        end
        chk("single_hit_pulses", pulses, 1);
        chk("window_len", win, N + 1);
        chk("back_to_ativo", int'(bus_if.db_estado), 1);

        // Held collision from 3 lives: one hit per window, then game over.
        step(1, 3, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 1, 0);
            if (bus_if.acerto) hits.push_back(i);
        end
        chk("held_hits", hits.size(), 3);
        if (hits.size() == 3) begin
            chk("held_hit0", hits[0], 0);
            chk("held_hit1", hits[1], N + 2);
            chk("held_hit2", hits[2], 2 * (N + 2));
        end
        chk("held_dead", int'(bus_if.sem_vidas), 1);
        chk("held_db", int'(bus_if.db_estado), 4);

        // Reload from MORTO, then clamp of 0.
        step(1, 7, 0, 0);
        chk("reload7_vidas", int'(bus_if.vidas), 7);
        chk("reload7_alive", int'(bus_if.sem_vidas), 0);
        step(1, 0, 0, 0);
        chk("clamp0_vidas", int'(bus_if.vidas), 1);

        // Load in the middle of the window.
        step(1, 3, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 4, 0, 0);
        chk("midwin_vidas", int'(bus_if.vidas), 4);
        chk("midwin_inv", int'(bus_if.invulneravel), 0);
        step(0, 0, 1, 0);
        chk("midwin_next_hit", int'(bus_if.acerto), 1);
        chk("midwin_next_vidas", int'(bus_if.vidas), 3);

        // Reset while a hit is being shown.
        async_reset();
        step(1, 2, 0, 0);
        step(0, 0, 1, 0);
        async_reset();
        chk("rst_midhit_acerto", int'(bus_if.acerto), 0);

        // Extra life behaviour.
        step(1, 7, 0, 0);
        step(0, 0, 0, 1);
        chk("extra_sat", int'(bus_if.vidas), 7);
        step(1, 2, 0, 0);
        step(0, 0, 0, 1);
        chk("extra_at2", int'(bus_if.vidas), EXTRA ? 3 : 2);
        step(1, 2, 0, 0);
        step(0, 0, 1, 1);
        chk("extra_vs_hit", int'(bus_if.vidas), 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(299) == 0) begin
                async_reset();
            end else begin
                step(($urandom_range(24) == 0),
                     int'($urandom_range(7)),
                     ($urandom_range(2) == 0),
                     ($urandom_range(3) == 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
